// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: four-way round-robin arbiter for a shared datapath.
// Registered one-hot grant, per-grant hold counter that revokes the grant
// at MAX_HOLD cycles (one-cycle timeout pulse), and a mandatory idle
// turnaround cycle between consecutive grants.
// Optional feature: define ARB_PARITY_EN to add the 'par' output, the even
// parity of the registered status {busy, grant_id, grant}.
module bus_arbiter_rr #(
   parameter int CW       = 4,
   parameter int MAX_HOLD = 15
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [3:0]    req,
   input  logic          done,
   output logic [3:0]    grant,
   output logic [1:0]    grant_id,
   output logic          busy,
   output logic [CW-1:0] hold_cnt,
`ifdef ARB_PARITY_EN
   output logic          par,
`endif
   output logic          timeout
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } state_t;

   state_t        state;
   state_t        next_state;
   logic [1:0]    last_id;
   logic [1:0]    next_last_id;
   logic [3:0]    next_grant;
   logic [1:0]    next_grant_id;
   logic          next_busy;
   logic [CW-1:0] next_hold_cnt;
   logic          next_timeout;
   logic [1:0]    winner;
   logic          owner_done;
   logic          owner_dropped;
   logic          hold_limit;

   // Pick the first requester after the previous owner; walking the offsets
   // from farthest to nearest lets the nearest set bit take the final say.
   always_comb begin
      winner = last_id + 2'd1;
      for (int k = 4; k >= 1; k--) begin
         if (req[last_id + 2'(k)]) begin
            winner = last_id + 2'(k);
         end
      end
   end

   // Next-state and next-output logic; every register holds unless a
   // transition below changes it, and timeout falls back to zero each cycle.
   always_comb begin
      next_state    = state;
      next_last_id  = last_id;
      next_grant    = grant;
      next_grant_id = grant_id;
      next_busy     = busy;
      next_hold_cnt = hold_cnt;
      next_timeout  = 1'b0;
      owner_done    = done;
      owner_dropped = ~req[grant_id];
      hold_limit    = (hold_cnt == CW'(MAX_HOLD - 1));
      unique case (state)
         IDLE: begin
            if (|req) begin
               next_state    = GRANT;
               next_grant    = 4'b0001 << winner;
               next_grant_id = winner;
               next_busy     = 1'b1;
               next_hold_cnt = '0;
            end
         end
         GRANT: begin
            if (owner_done || owner_dropped || hold_limit) begin
               next_state    = TURN;
               next_grant    = 4'b0000;
               next_busy     = 1'b0;
               next_hold_cnt = '0;
               next_last_id  = grant_id;
               next_timeout  = hold_limit && !owner_done && !owner_dropped;
            end else begin
               next_hold_cnt = hold_cnt + CW'(1);
            end
         end
         TURN: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // State and registered outputs; reset leaves requester 0 first in line.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         last_id  <= 2'd3;
         grant    <= 4'b0000;
         grant_id <= 2'd0;
         busy     <= 1'b0;
         hold_cnt <= '0;
         timeout  <= 1'b0;
      end else begin
         state    <= next_state;
         last_id  <= next_last_id;
         grant    <= next_grant;
         grant_id <= next_grant_id;
         busy     <= next_busy;
         hold_cnt <= next_hold_cnt;
         timeout  <= next_timeout;
      end
   end

`ifdef ARB_PARITY_EN
   // Parity of the registered status for the downstream checker.
   always_comb begin
      par = ^{busy, grant_id, grant};
   end
`endif

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb_bus_arbiter_rr: self-checking bench for bus_arbiter_rr. A behavioural
// model tracks the current owner, its hold time, the turnaround gap and the
// previous owner, and predicts the arbiter's outputs cycle by cycle.
module tb_bus_arbiter_rr;

   localparam int CW       = 4;
   localparam int MAX_HOLD = 15;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [3:0]    req;
   logic          done;
   logic [3:0]    grant;
   logic [1:0]    grant_id;
   logic          busy;
   logic [CW-1:0] hold_cnt;
   logic          timeout;
`ifdef ARB_PARITY_EN
   logic          par;
`endif

   int compared   = 0;
   int mismatched = 0;

   // Behavioural model: owner is -1 when nobody holds the resource.
   int m_owner;
   int m_hold;
   int m_last;
   int m_gid;
   bit m_turn;
   bit m_timeout;

   bus_arbiter_rr #(.CW(CW), .MAX_HOLD(MAX_HOLD)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .req      (req),
      .done     (done),
      .grant    (grant),
      .grant_id (grant_id),
      .busy     (busy),
      .hold_cnt (hold_cnt),
`ifdef ARB_PARITY_EN
      .par      (par),
`endif
      .timeout  (timeout)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   task automatic model_reset();
      m_owner   = -1;
      m_hold    = 0;
      m_last    = 3;
      m_gid     = 0;
      m_turn    = 1'b0;
      m_timeout = 1'b0;
   endtask

   // Advance the model by one clock edge using the inputs as they stand.
   task automatic model_step();
      bit a, b, c;
      m_timeout = 1'b0;
      if (m_owner >= 0) begin
         a = done;
         b = !req[m_owner];
         c = (m_hold == MAX_HOLD - 1);
         if (a || b || c) begin
            m_timeout = c && !a && !b;
            m_last    = m_owner;
            m_owner   = -1;
            m_hold    = 0;
            m_turn    = 1'b1;
         end else begin
            m_hold = m_hold + 1;
         end
      end else if (m_turn) begin
         m_turn = 1'b0;
      end else if (req != 4'b0000) begin
         for (int k = 4; k >= 1; k--) begin
            if (req[(m_last + k) % 4]) m_owner = (m_last + k) % 4;
         end
         m_gid  = m_owner;
         m_hold = 0;
      end
   endtask

   function automatic logic [11:0] model_vec();
      logic [3:0] g;
      logic [1:0] id;
      g  = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      id = (m_owner >= 0) ? 2'(m_gid) : 2'b00;
      return {g, (m_owner >= 0), id, 4'(m_hold), m_timeout};
   endfunction

   function automatic logic [11:0] dut_vec();
      return {grant, busy, (busy ? grant_id : 2'b00), hold_cnt, timeout};
   endfunction

   // One clock edge: model follows the same inputs, then settle past the edge.
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      req     = 4'b1111;
      done    = 1'b0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      compared++;
      if ({grant, grant_id, busy, hold_cnt, timeout} !== 12'h000) begin
         mismatched++;
         $display("[TB] FAIL reset_state: got %h expected %h",
                  {grant, grant_id, busy, hold_cnt, timeout}, 12'h000);
      end
      reset_n = 1'b1;
   endtask

   task automatic test_rotation();
      logic [3:0] seen[$];
      logic [3:0] expected[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic [3:0] prev = 4'b0000;
      int gaps = 0;
      req = 4'b1111;
      for (int i = 0; i < 40 && seen.size() < 5; i++) begin
         done = (m_owner >= 0);
         tick();
         compared++;
         if (dut_vec() !== model_vec()) begin
            mismatched++;
            $display("[TB] FAIL rotation_step %0d: got %h expected %h", i, dut_vec(), model_vec());
         end
         if (grant == 4'b0000 && prev != 4'b0000) gaps++;
         if (grant != 4'b0000 && prev == 4'b0000) seen.push_back(grant);
         prev = grant;
      end
      compared++;
      if (seen.size() != 5) begin
         mismatched++;
         $display("[TB] FAIL rotation_count: got %0d grants expected 5", seen.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            compared++;
            if (seen[i] !== expected[i]) begin
               mismatched++;
               $display("[TB] FAIL rotation_order[%0d]: got %b expected %b", i, seen[i], expected[i]);
            end
         end
      end
      compared++;
      if (gaps < 4) begin
         mismatched++;
         $display("[TB] FAIL rotation_gaps: got %0d expected at least 4", gaps);
      end
      done = 1'b0;
      req  = 4'b0000;
      repeat (4) tick();
   endtask

   task automatic test_single();
      req  = 4'b0100;
      done = 1'b0;
      tick();
      compared++;
      if ({grant, grant_id, hold_cnt} !== {4'b0100, 2'd2, 4'd0}) begin
         mismatched++;
         $display("[TB] FAIL single_grant: got %b/%0d/%0d expected 0100/2/0", grant, grant_id, hold_cnt);
      end
      for (int n = 1; n <= 2; n++) begin
         tick();
         compared++;
         if (hold_cnt !== 4'(n) || grant !== 4'b0100) begin
            mismatched++;
            $display("[TB] FAIL single_hold: got %0d/%b expected %0d/0100", hold_cnt, grant, n);
         end
      end
      done = 1'b1;
      tick();
      compared++;
      if ({grant, busy, timeout} !== 6'b0) begin
         mismatched++;
         $display("[TB] FAIL single_done: got %b/%b/%b expected 0000/0/0", grant, busy, timeout);
      end
      done = 1'b0;
      req  = 4'b0000;
      repeat (3) tick();
   endtask

   task automatic test_timeout();
      int grant_cycles = 0;
      int pulses = 0;
      int max_hold = 0;
      req  = 4'b0010;
      done = 1'b0;
      for (int i = 0; i < MAX_HOLD + 6; i++) begin
         tick();
         if (grant == 4'b0010) grant_cycles++;
         if (timeout) begin
            pulses++;
            req = 4'b0000;
         end
         if (int'(hold_cnt) > max_hold) max_hold = int'(hold_cnt);
      end
      compared++;
      if (grant_cycles != MAX_HOLD) begin
         mismatched++;
         $display("[TB] FAIL timeout_cycles: got %0d expected %0d", grant_cycles, MAX_HOLD);
      end
      compared++;
      if (pulses != 1) begin
         mismatched++;
         $display("[TB] FAIL timeout_pulses: got %0d expected 1", pulses);
      end
      compared++;
      if (max_hold != MAX_HOLD - 1) begin
         mismatched++;
         $display("[TB] FAIL timeout_maxhold: got %0d expected %0d", max_hold, MAX_HOLD - 1);
      end
      req = 4'b0000;
      repeat (3) tick();
   endtask

   task automatic test_drop();
      req  = 4'b1000;
      done = 1'b0;
      tick();
      compared++;
      if (grant !== 4'b1000 || grant_id !== 2'd3) begin
         mismatched++;
         $display("[TB] FAIL drop_owner: got %b/%0d expected 1000/3", grant, grant_id);
      end
      req = 4'b0111;
      tick();
      compared++;
      if (grant !== 4'b0000 || timeout !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL drop_release: got %b/%b expected 0000/0", grant, timeout);
      end
      tick();
      compared++;
      if (grant !== 4'b0000) begin
         mismatched++;
         $display("[TB] FAIL drop_turn: got %b expected 0000", grant);
      end
      tick();
      compared++;
      if (grant !== 4'b0001 || grant_id !== 2'd0) begin
         mismatched++;
         $display("[TB] FAIL drop_next: got %b/%0d expected 0001/0", grant, grant_id);
      end
      req = 4'b0000;
      repeat (3) tick();
   endtask

   task automatic test_done_at_timeout();
      int waited = 0;
      req  = 4'b0001;
      done = 1'b0;
      tick();
      while (hold_cnt != 4'(MAX_HOLD - 1) && waited < 40) begin
         tick();
         waited++;
      end
      compared++;
      if (waited >= 40) begin
         mismatched++;
         $display("[TB] FAIL collide_wait: got hold %0d expected %0d", hold_cnt, MAX_HOLD - 1);
      end
      done = 1'b1;
      tick();
      compared++;
      if ({grant, busy, timeout} !== 6'b0) begin
         mismatched++;
         $display("[TB] FAIL collide_release: got %b/%b/%b expected 0000/0/0", grant, busy, timeout);
      end
      done = 1'b0;
      req  = 4'b0000;
      tick();
      compared++;
      if (timeout !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL collide_pulse: got %b expected 0", timeout);
      end
      repeat (2) tick();
      // Asynchronous reset while a grant is active.
      req = 4'b0100;
      tick();
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      compared++;
      if ({grant, busy, hold_cnt, timeout, grant_id} !== 12'h000) begin
         mismatched++;
         $display("[TB] FAIL async_reset: got %b/%b/%0d/%b/%0d expected 0000/0/0/0/0",
                  grant, busy, hold_cnt, timeout, grant_id);
      end
      model_reset();
      req = 4'b0000;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 7) == 0) req = 4'($urandom);
         done = ($urandom_range(0, 5) == 0);
         tick();
         compared++;
         if (dut_vec() !== model_vec()) begin
            mismatched++;
            $display("[TB] FAIL random_step %0d: got %h expected %h", i, dut_vec(), model_vec());
         end
`ifdef ARB_PARITY_EN
         compared++;
         if (par !== ^{(m_owner >= 0), 2'(m_gid), model_vec()[11:8]}) begin
            mismatched++;
            $display("[TB] FAIL random_par %0d: got %b", i, par);
         end
`endif
      end
      req  = 4'b0000;
      done = 1'b0;
   endtask

   initial begin
      test_reset();
      test_rotation();
      test_single();
      test_timeout();
      test_drop();
      test_done_at_timeout();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
